// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave front end for the single-port RAM path.
// Deserialises a (DATA_W+2)-bit command-prefixed frame from MOSI and hands it to the
// RAM controller. For read-data commands it waits for tx_valid, then serialises
// tx_data on MISO. SS_n rising mid-frame is reported on frame_err.
//
// Ports:
//   clk       serial clock, all logic on rising edge
//   rst       asynchronous reset, active-high
//   SS_n      slave select, active-low
//   MOSI      serial data in
//   MISO      serial data out (registered)
//   rx_data   received frame, command in the top two bits, payload below (registered)
//   rx_valid  one-cycle pulse when a frame completes (registered)
//   tx_data   read data from RAM
//   tx_valid  tx_data valid, only looked at while waiting to transmit
//   frame_err one-cycle pulse when a frame is aborted by SS_n (registered)
module spi_slave_param #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              frame_err
);
    localparam int unsigned      FRAME_W = DATA_W + 2;
    localparam int unsigned      CNT_W   = $clog2(DATA_W + 3);
    localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WAIT_TX,
        SEND,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
    logic [FRAME_W-1:0] rx_shift;
    logic [DATA_W-1:0]  tx_sr_q, tx_sr_d;
    logic [FRAME_W-1:0] rx_data_d;
    logic               miso_d;
    logic               rx_valid_d;
    logic               frame_err_d;

    // Bit that leaves the TX shifter first, per bit order.
    function automatic logic tx_head(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction

    // TX shifter after its head bit has been sent.
    function automatic logic [DATA_W-1:0] tx_next(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    // New MOSI bit enters at the end that leaves the completed frame MSB-aligned.
    assign rx_shift = LSB_FIRST ? {MOSI, rx_sr_q[FRAME_W-1:1]}
                                : {rx_sr_q[FRAME_W-2:0], MOSI};

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            rx_data   <= '0;
            MISO      <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            rx_data   <= rx_data_d;
            MISO      <= miso_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_data_d   = rx_data;
        miso_d      = 1'b0;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!SS_n) begin
                    rx_sr_d = rx_shift;
                    cnt_d   = ONE;
                    state_d = RECV;
                end
            end
            RECV: begin
                // SS_n wins over the bit sampled on the same edge.
                if (SS_n) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else begin
                    rx_sr_d = rx_shift;
                    if (cnt_q == LAST_RX) begin
                        rx_data_d  = rx_shift;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = (rx_shift[FRAME_W-1:FRAME_W-2] == 2'b11) ? WAIT_TX : DONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            WAIT_TX: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else if (tx_valid) begin
                    // First bit goes out on the same edge tx_data is captured.
                    miso_d  = tx_head(tx_data);
                    tx_sr_d = tx_next(tx_data);
                    cnt_d   = ONE;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (SS_n) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                end else if (cnt_q == LAST_TX) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    miso_d  = tx_head(tx_sr_q);
                    tx_sr_d = tx_next(tx_sr_q);
                    cnt_d   = cnt_q + ONE;
                end
            end
            DONE: begin
                if (SS_n) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
endmodule
